// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end sitting between instruction memory
// and the decoder.
//
// A free-running fetch pointer issues requests to memory over a valid/ready
// request channel, with up to MAX_OUT requests in flight. Responses come back
// in request order and land in a DEPTH-entry prefetch FIFO. The decoder takes
// instructions from that FIFO over a valid/ready handshake. A redirect flushes
// the FIFO, restarts fetching at a new address, and discards every response
// that is still in flight.
//
// Ports:
//   clk             rising-edge clock
//   _reset          asynchronous active-low reset, released synchronously
//   mem_req_valid   request to memory      mem_req_ready   memory accepts
//   mem_req_addr    fetch address
//   mem_resp_valid  in-order response      mem_resp_data   fetched word
//   instr_valid     head entry valid       instr_ready     decoder consumes
//   instr_data      head instruction       instr_addr      head address
//   redirect_valid  change fetch stream    redirect_addr   new fetch address
//   fifo_count      occupied FIFO entries

// Protocol checker: memory must never answer a request that was never issued.
module fetch_unit_chk #(
    parameter int OUT_W = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic             resp_valid,
    input logic [OUT_W-1:0] outstanding
);
    a_resp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid |-> (outstanding != {OUT_W{1'b0}}));
endmodule

module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter int                STEP     = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                    clk,
    input  logic                    _reset,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_W-1:0]       mem_req_addr,
    input  logic                    mem_resp_valid,
    input  logic [INSTR_W-1:0]      mem_resp_data,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [INSTR_W-1:0]      instr_data,
    output logic [ADDR_W-1:0]       instr_addr,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_addr,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUT) + 1;
    localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_resp_pc;
    logic [INSTR_W-1:0] r_data_mem [DEPTH];
    logic [ADDR_W-1:0]  r_addr_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [OUT_W-1:0]   r_outstanding;
    logic [OUT_W-1:0]   r_drop_cnt;

    logic               w_req_fire;
    logic               w_pop;
    logic               w_resp_ok;
    logic               w_push;
    logic [SUM_W-1:0]   w_inflight;
    logic [OUT_W-1:0]   w_out_after_resp;
    logic [OUT_W-1:0]   w_out_next;
    logic [CNT_W-1:0]   w_count_next;

    // Handshakes, credit check and the decoder-facing head entry.
    always_comb begin
        // Counting FIFO entries plus in-flight requests guarantees every
        // response finds a free slot, so memory never needs backpressure.
        w_inflight    = SUM_W'(r_count) + SUM_W'(r_outstanding);
        mem_req_valid = _reset && !redirect_valid
                        && (r_outstanding < OUT_W'(MAX_OUT))
                        && (w_inflight < SUM_W'(DEPTH));
        mem_req_addr  = r_pc;
        w_req_fire    = mem_req_valid && mem_req_ready;

        instr_valid   = (r_count != {CNT_W{1'b0}}) && !redirect_valid;
        w_pop         = instr_valid && instr_ready;
        if (r_count != {CNT_W{1'b0}}) begin
            instr_data = r_data_mem[r_rd_ptr];
            instr_addr = r_addr_mem[r_rd_ptr];
        end else begin
            instr_data = {INSTR_W{1'b0}};
            instr_addr = {ADDR_W{1'b0}};
        end

        // A response with nothing outstanding is a memory protocol error and
        // is ignored entirely.
        w_resp_ok        = mem_resp_valid && (r_outstanding != {OUT_W{1'b0}});
        w_push           = w_resp_ok && !redirect_valid && (r_drop_cnt == {OUT_W{1'b0}});
        w_out_after_resp = r_outstanding - OUT_W'(w_resp_ok);
        w_out_next       = w_out_after_resp + OUT_W'(w_req_fire);
        w_count_next     = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        fifo_count       = r_count;
    end

    // Fetch pointer and the address tag given to the next accepted response.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc      <= redirect_addr;
            r_resp_pc <= redirect_addr;
        end else begin
            if (w_req_fire) begin
                r_pc <= r_pc + STEP_A;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + STEP_A;
            end
        end
    end

    // In-flight request count and the number of stale responses to discard.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_outstanding <= {OUT_W{1'b0}};
            r_drop_cnt    <= {OUT_W{1'b0}};
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the
                // old stream.
                r_drop_cnt <= w_out_after_resp;
            end else if (w_resp_ok && (r_drop_cnt != {OUT_W{1'b0}})) begin
                r_drop_cnt <= r_drop_cnt - {{(OUT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Prefetch FIFO pointers and occupancy; a redirect empties it.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            r_count <= w_count_next;
        end
    end

    // FIFO storage; contents are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= mem_resp_data;
            r_addr_mem[r_wr_ptr] <= r_resp_pc;
        end
    end

    fetch_unit_chk #(.OUT_W(OUT_W)) u_chk (
        .clk         (clk),
        .rst_n       (_reset),
        .resp_valid  (mem_resp_valid),
        .outstanding (r_outstanding)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a default-parameter instance driven by a
// random-latency in-order memory and a random decoder, compared every cycle
// against a queue-based model of the fetch stream, plus an 8-bit-address
// instance that streams across the address wrap.
module tb_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;

    logic        clk = 1'b0;
    logic        rst_n_tb;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_resp_data;
    logic        instr_valid, instr_ready, redirect_valid;
    logic [31:0] instr_data, instr_addr, redirect_addr;
    logic [2:0]  fifo_count;

    logic        w8_req_valid, w8_resp_valid, w8_instr_valid;
    logic [7:0]  w8_req_addr, w8_instr_addr;
    logic [31:0] w8_resp_data, w8_instr_data;
    logic [2:0]  w8_count;

    int          n_checks = 0;
    int          n_errors = 0;
    req_t        pend[$];
    ent_t        q[$];
    logic [31:0] pc_m;
    int          cyc = 0, epoch = 0, last_due = 0, w8_pops = 0;
    int          p_mready, p_ready, p_redir, lat_min, lat_max;
    bit          want_r2 = 1'b0, want_co = 1'b0, hit = 1'b0, rel_req = 1'b0;
    logic        w8_fired;
    logic [7:0]  w8_faddr, wexp;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), ._reset(rst_n_tb),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_addr(instr_addr),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .fifo_count(fifo_count)
    );

    fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFE)) u_wrap (
        .clk(clk), ._reset(rst_n_tb),
        .mem_req_valid(w8_req_valid), .mem_req_ready(1'b1), .mem_req_addr(w8_req_addr),
        .mem_resp_valid(w8_resp_valid), .mem_resp_data(w8_resp_data),
        .instr_valid(w8_instr_valid), .instr_ready(1'b1),
        .instr_data(w8_instr_data), .instr_addr(w8_instr_addr),
        .redirect_valid(1'b0), .redirect_addr(8'h00),
        .fifo_count(w8_count)
    );

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        q.delete();
        pc_m     = RESET_PC;
        last_due = cyc;
        w8_fired = 1'b0;
        wexp     = 8'hFE;
    endtask

    task automatic check_update();
        req_t p;
        ent_t e;
        logic exp_rv, exp_iv, fire;
        if (!rst_n_tb) begin
            chk_eq("rst_req_valid", mem_req_valid, 0);
            chk_eq("rst_req_addr", mem_req_addr, RESET_PC);
            chk_eq("rst_instr_valid", instr_valid, 0);
            chk_eq("rst_count", fifo_count, 0);
            chk_eq("rst_wrap_addr", w8_req_addr, 8'hFE);
            chk_eq("rst_wrap_count", w8_count, 0);
            model_reset();
        end else begin
            exp_rv = !redirect_valid && (pend.size() < MAX_OUT) && (q.size() + pend.size() < DEPTH);
            exp_iv = (q.size() != 0) && !redirect_valid;
            chk_eq("req_valid", mem_req_valid, exp_rv);
            chk_eq("req_addr", mem_req_addr, pc_m);
            chk_eq("instr_valid", instr_valid, exp_iv);
            chk_eq("fifo_count", fifo_count, q.size());
            if (exp_iv) begin
                chk_eq("instr_addr", instr_addr, q[0].addr);
                chk_eq("instr_data", instr_data, q[0].data);
            end
            fire = exp_rv && mem_req_ready;
            if (exp_iv && instr_ready) void'(q.pop_front());
            if (mem_resp_valid) begin
                p = pend.pop_front();
                // Responses to requests from before a redirect never surface.
                if (!redirect_valid && p.epoch == epoch) begin
                    e.addr = p.addr;
                    e.data = p.addr * 32'd3;
                    q.push_back(e);
                end
            end
            if (fire) begin
                p.addr  = pc_m;
                p.epoch = epoch;
                p.due   = cyc + int'($urandom_range(lat_max, lat_min));
                if (p.due <= last_due) p.due = last_due + 1;
                last_due = p.due;
                pend.push_back(p);
                pc_m = pc_m + 32'd1;
            end
            if (redirect_valid) begin
                q.delete();
                epoch++;
                pc_m = redirect_addr;
            end
            if (w8_instr_valid) begin
                chk_eq("wrap_addr", w8_instr_addr, wexp);
                chk_eq("wrap_data", w8_instr_data, 32'(wexp) * 32'd3);
                wexp = wexp + 8'd1;
                w8_pops++;
            end
            w8_fired = w8_req_valid;
            w8_faddr = w8_req_addr;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (rel_req) begin
            rst_n_tb = 1'b1;
            rel_req  = 1'b0;
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = pend[0].addr * 32'd3;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
        end
        mem_req_ready  = ($urandom_range(99) < p_mready);
        instr_ready    = ($urandom_range(99) < p_ready);
        redirect_valid = 1'b0;
        redirect_addr  = $urandom;
        if (rst_n_tb) begin
            if ($urandom_range(99) < p_redir) redirect_valid = 1'b1;
            if (want_r2 && pend.size() == 2 && q.size() >= 1) begin
                redirect_valid = 1'b1;
                redirect_addr  = 32'h100;
                want_r2 = 1'b0;
                hit     = 1'b1;
            end
            if (want_co && mem_resp_valid && q.size() > 0) begin
                redirect_valid = 1'b1;
                instr_ready    = 1'b1;
                want_co = 1'b0;
                hit     = 1'b1;
            end
        end
        w8_resp_valid = w8_fired;
        w8_resp_data  = 32'(w8_faddr) * 32'd3;
        @(negedge clk);
        check_update();
    endtask

    task automatic set_mode(input int mr, input int rd, input int rr, input int lmin, input int lmax);
        p_mready = mr; p_ready = rd; p_redir = rr; lat_min = lmin; lat_max = lmax;
    endtask

    initial begin
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0;
        w8_resp_valid = 1'b0; w8_resp_data = 32'h0;
        set_mode(100, 100, 0, 1, 1);
        rst_n_tb = 1'b1;
        #1 rst_n_tb = 1'b0;
        #1;
        chk_eq("init_req_valid", mem_req_valid, 0);
        chk_eq("init_req_addr", mem_req_addr, RESET_PC);
        chk_eq("init_instr_valid", instr_valid, 0);
        chk_eq("init_instr_data", instr_data, 0);
        chk_eq("init_instr_addr", instr_addr, 0);
        chk_eq("init_count", fifo_count, 0);
        model_reset();
        cycle(); cycle();
        rel_req = 1'b1;

        // Streaming with 1-cycle memory and an always-ready decoder.
        set_mode(100, 100, 0, 1, 1);
        repeat (30) cycle();

        // Decoder backpressure fills the FIFO, then drains it.
        set_mode(100, 0, 0, 1, 1);
        repeat (12) cycle();
        chk_eq("bp_full", fifo_count, DEPTH);
        chk_eq("bp_no_req", mem_req_valid, 0);
        set_mode(100, 100, 0, 1, 1);
        repeat (10) cycle();

        // Redirect to 0x100 with two requests in flight and a buffered entry.
        set_mode(100, 30, 0, 3, 3);
        hit = 1'b0; want_r2 = 1'b1;
        for (int n = 0; n < 300 && !hit; n++) cycle();
        chk_eq("r2_reached", hit, 1);
        want_r2 = 1'b0;
        repeat (20) cycle();

        // Redirect coinciding with a response and a ready decoder.
        set_mode(100, 60, 0, 1, 3);
        hit = 1'b0; want_co = 1'b1;
        for (int n = 0; n < 300 && !hit; n++) cycle();
        chk_eq("co_reached", hit, 1);
        want_co = 1'b0;
        repeat (20) cycle();

        // Asynchronous reset between edges with three buffered, one in flight.
        set_mode(100, 20, 0, 1, 2);
        hit = 1'b0;
        for (int n = 0; n < 300 && !hit; n++) begin
            cycle();
            if (q.size() == 3 && pend.size() == 1) hit = 1'b1;
        end
        chk_eq("mid_rst_reached", hit, 1);
        @(posedge clk);
        #2;
        chk_eq("pre_rst_instr_valid", instr_valid, 1);
        #1 rst_n_tb = 1'b0;
        #1;
        chk_eq("mid_rst_instr_valid", instr_valid, 0);
        chk_eq("mid_rst_req_valid", mem_req_valid, 0);
        chk_eq("mid_rst_count", fifo_count, 0);
        model_reset();
        cycle(); cycle();
        set_mode(100, 100, 0, 1, 1);
        rel_req = 1'b1;
        cycle();
        chk_eq("mid_rst_first_valid", mem_req_valid, 1);
        chk_eq("mid_rst_first_addr", mem_req_addr, RESET_PC);

        // Random traffic with random redirects and latencies.
        set_mode(70, 60, 6, 1, 3);
        repeat (2000) cycle();
        set_mode(100, 100, 0, 1, 3);
        repeat (20) cycle();

        chk_eq("wrap_pops_seen", (w8_pops >= 4), 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction fetch front end between instruction memory and the decoder.
- Generalises the bare instruction-pointer/instruction-in pair into the following:
  - a free-running fetch pointer;
  - a request/response memory interface that allows multiple requests in flight;
  - a DEPTH-entry prefetch FIFO with a valid/ready handshake to the decoder;
  - redirect support (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- ADDR_W, 32, width of instruction addresses.
- INSTR_W, 32, width of an instruction word.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- MAX_OUT, 2, maximum memory requests in flight; 1 to DEPTH.
- STEP, 1, address increment per instruction (word-addressed by default).
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- _reset  in  1  asynchronous, active-low reset.
- mem_req_valid  out  1  request to instruction memory.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_addr  out  ADDR_W  fetch address.
- mem_resp_valid  in  1  response word present; responses arrive in request order; no backpressure.
- mem_resp_data  in  INSTR_W  fetched instruction.
- instr_valid  out  1  head FIFO entry is valid.
- instr_ready  in  1  decoder consumes the head entry.
- instr_data  out  INSTR_W  head instruction.
- instr_addr  out  ADDR_W  address of the head instruction.
- redirect_valid  in  1  change the fetch stream.
- redirect_addr  in  ADDR_W  new fetch address.
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries, for debug and performance counters.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty; outstanding=0; drop_cnt=0.
  - All outputs low/zero, except mem_req_addr=RESET_PC.
- Request issue:
  - mem_req_valid = !redirect_valid && outstanding<MAX_OUT && (fifo_count+outstanding)<DEPTH.
  - This credit rule guarantees every response has a FIFO slot.
  - mem_req_addr=pc.
  - req_fire=valid&&ready; on fire, pc<=pc+STEP, modulo 2^ADDR_W (wraps silently).
  - valid may drop without a handshake only because of redirect or credit; the address is held stable while valid.
- Outstanding counter:
  - +1 on req_fire, -1 on mem_resp_valid.
  - Both in the same cycle leaves it unchanged.
  - A response with outstanding==0 is a protocol error: assertion in sim; ignored in RTL.
- Response handling:
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {mem_resp_data, resp_pc} is pushed into the FIFO and resp_pc<=resp_pc+STEP.
- Decoder side:
  - instr_valid = fifo_count!=0 && !redirect_valid.
  - instr_data/instr_addr come from the head entry (combinational read, 0-cycle latency).
  - pop=instr_valid&&instr_ready.
  - Push and pop in the same cycle are both legal, including when the FIFO is full (pop frees the slot) and when it holds one entry.
  - Data pushed in cycle N is visible at the head in cycle N+1 at the earliest.
  - Minimum fetch latency is 1 cycle from request to the memory response, then 1 cycle to instr_valid.
- Redirect (highest priority), in the cycle redirect_valid=1:
  - No request is issued and no pop happens.
  - Any response arriving that cycle is discarded.
  - At the edge:
    - FIFO is flushed (count=0, pointers reset);
    - pc<=redirect_addr and resp_pc<=redirect_addr;
    - drop_cnt <= outstanding - (mem_resp_valid?1:0), i.e. all requests still in flight are dropped;
    - outstanding decrements normally for the response that arrived.
  - Back-to-back redirects are legal; the last one wins, and drop_cnt is recomputed each time.
  - The first post-redirect request is issued the next cycle, provided credit allows.
- Steady state with a 1-cycle memory and an always-ready decoder: one instruction per cycle.
- Reset asserted mid-transfer clears everything immediately; in-flight memory responses after release are the memory's responsibility (memory is reset by the same signal).

Test Plan:
- Streaming: reset release, memory with 1-cycle latency returning data=addr*3, instr_ready=1 -> instr_addr 0,1,2,3… consecutive cycles with instr_data 0,3,6,9; no bubble after the first valid.
- Backpressure: instr_ready=0 for 10 cycles -> fifo_count saturates at 4, at most 4 requests ever issued, mem_req_valid low once count+outstanding=4; release -> addresses 0..3 popped, then 4 continues with no drop or duplicate.
- Redirect with 2 in flight: MAX_OUT=2, 3-cycle memory latency; redirect_addr=0x100 while outstanding=2 and FIFO holds 1 -> FIFO empties, next 2 responses discarded, first instr_addr seen=0x100 with the correct data.
- Redirect coincident with a response and a pop: redirect_valid, mem_resp_valid and instr_ready all high -> no pop counted, response dropped, drop_cnt=outstanding-1, next delivered address=redirect_addr.
- Wrap-around: ADDR_W=8, RESET_PC=0xFE, STEP=1 -> instr_addr sequence 0xFE, 0xFF, 0x00, 0x01.
- Async reset mid-operation: _reset low between edges while FIFO=3 and outstanding=1 -> instr_valid and mem_req_valid fall immediately, fifo_count=0; after release the first request addr=RESET_PC.
